// File: rtl/ncl_seq_pkg.sv
// rtl/ncl_seq_pkg.sv - shared state encoding, rail constants and rail helper for ncl_add_seq
package ncl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA_WAIT,
    NULL_WAIT,
    RESP,
    ERR
  } state_t;

  // Dual-rail pair encoding: {rail1, rail0}
  localparam logic [1:0] RAIL_NULL  = 2'b00;
  localparam logic [1:0] RAIL_DATA0 = 2'b01;
  localparam logic [1:0] RAIL_DATA1 = 2'b10;
  localparam logic [1:0] RAIL_ILL   = 2'b11;

  function automatic logic [1:0] rail_enc(input logic b);
    return b ? RAIL_DATA1 : RAIL_DATA0;
  endfunction

endpackage

// File: rtl/ncl_add_seq_if.sv
// rtl/ncl_add_seq_if.sv - operand/result handshake bundle for ncl_add_seq
// master: operand producer / result consumer; slave: the sequencer.
interface ncl_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_cout
  );
endinterface

// File: rtl/ncl_sync2.sv
// rtl/ncl_sync2.sv - parameterized two-flop synchronizer, async active-low reset
// Ports: clk, rst_n, i_d (async input bus), o_q (synchronized output).
module ncl_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/ncl_add_seq.sv
// rtl/ncl_add_seq.sv - synchronous sequencer driving a dual-rail NCL ripple adder
// Ports: clk, init_n (async active-low reset), bus (ncl_add_seq_if.slave: req/resp
// handshakes), a_dr/b_dr/cin_dr (dual-rail operands out), sum_dr/cout_dr/comp_in
// (async adder results and completion in), comp_out (1 = request NULL), err/err_clr.
// Optional: NCL_SEQ_TIMEOUT_EN enables a TMO_CYCLES watchdog in DATA_WAIT/NULL_WAIT.
module ncl_add_seq
  import ncl_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic               clk,
  input  logic               init_n,
  ncl_add_seq_if.slave       bus,
  output logic [2*WIDTH-1:0] a_dr,
  output logic [2*WIDTH-1:0] b_dr,
  output logic [1:0]         cin_dr,
  input  logic [2*WIDTH-1:0] sum_dr,
  input  logic [1:0]         cout_dr,
  input  logic               comp_in,
  output logic               comp_out,
  output logic               err,
  input  logic               err_clr
);
  localparam int SW = 2*WIDTH + 3;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_a_dr, r_b_dr;
  logic [1:0]         r_cin_dr;
  logic               r_comp_out, r_req_ready, r_resp_valid, r_resp_cout, r_err;
  logic [WIDTH-1:0]   r_resp_sum;

  // Everything coming back from the adder is asynchronous to clk.
  logic [SW-1:0]      w_sync;
  logic [2*WIDTH-1:0] w_sum_s;
  logic [1:0]         w_cout_s;
  logic               w_comp_s;

  ncl_sync2 #(.W(SW)) u_sync (
    .clk   (clk),
    .rst_n (init_n),
    .i_d   ({comp_in, cout_dr, sum_dr}),
    .o_q   (w_sync)
  );

  assign {w_comp_s, w_cout_s, w_sum_s} = w_sync;

  logic               w_all_data, w_all_null, w_any_ill;
  logic [WIDTH-1:0]   w_sum_bits;
  logic [2*WIDTH-1:0] w_a_enc, w_b_enc;

  always_comb begin
    w_all_data = (w_cout_s == RAIL_DATA0) || (w_cout_s == RAIL_DATA1);
    w_all_null = (w_cout_s == RAIL_NULL);
    w_any_ill  = (w_cout_s == RAIL_ILL);
    w_sum_bits = '0;
    w_a_enc    = '0;
    w_b_enc    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!((w_sum_s[2*i +: 2] == RAIL_DATA0) || (w_sum_s[2*i +: 2] == RAIL_DATA1)))
        w_all_data = 1'b0;
      if (w_sum_s[2*i +: 2] != RAIL_NULL)
        w_all_null = 1'b0;
      if (w_sum_s[2*i +: 2] == RAIL_ILL)
        w_any_ill = 1'b1;
      w_sum_bits[i]     = w_sum_s[2*i+1];
      w_a_enc[2*i +: 2] = rail_enc(bus.req_a[i]);
      w_b_enc[2*i +: 2] = rail_enc(bus.req_b[i]);
    end
  end

  logic w_data_done, w_null_done, w_waiting, w_tmo, w_to_err;

  assign w_data_done = w_comp_s && w_all_data;
  assign w_null_done = !w_comp_s && w_all_null;
  assign w_waiting   = (r_state == DATA_WAIT) || (r_state == NULL_WAIT);

`ifdef NCL_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  // Cleared outside the wait states and on the DATA_WAIT->NULL_WAIT hop,
  // so each wait state starts counting from zero.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)
      r_wd <= '0;
    else if (!w_waiting || ((r_state == DATA_WAIT) && w_data_done))
      r_wd <= '0;
    else
      r_wd <= r_wd + 1'b1;
  end

  assign w_tmo = (r_wd == WD_W'(TMO_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // Illegal rails take priority over a simultaneous completion.
  assign w_to_err = w_waiting && (w_any_ill || w_tmo);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state      <= IDLE;
      r_a_dr       <= '0;
      r_b_dr       <= '0;
      r_cin_dr     <= RAIL_NULL;
      r_comp_out   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_sum   <= '0;
      r_resp_cout  <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_to_err) begin
      r_state      <= ERR;
      r_err        <= 1'b1;
      r_a_dr       <= '0;
      r_b_dr       <= '0;
      r_cin_dr     <= RAIL_NULL;
      r_comp_out   <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_a_dr      <= w_a_enc;
            r_b_dr      <= w_b_enc;
            r_cin_dr    <= rail_enc(bus.req_cin);
            r_req_ready <= 1'b0;
            r_state     <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (w_data_done) begin
            r_resp_sum  <= w_sum_bits;
            r_resp_cout <= w_cout_s[1];
            r_a_dr      <= '0;
            r_b_dr      <= '0;
            r_cin_dr    <= RAIL_NULL;
            r_comp_out  <= 1'b1;
            r_state     <= NULL_WAIT;
          end
        end
        NULL_WAIT: begin
          if (w_null_done) begin
            r_comp_out   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        ERR: begin
          if (err_clr) begin
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_dr           = r_a_dr;
  assign b_dr           = r_b_dr;
  assign cin_dr         = r_cin_dr;
  assign comp_out       = r_comp_out;
  assign err            = r_err;
  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_sum   = r_resp_sum;
  assign bus.resp_cout  = r_resp_cout;
endmodule
